// File: rtl/op_loader_pkg.sv
// Shared definitions for the opcode-image path: address/data width
// defaults, the loader state encoding and the opcode set that the
// exec unit decodes from the image the loader writes.
package op_loader_pkg;

  localparam int ASZ_DEF = 17;
  localparam int DSZ_DEF = 8;

  // Loader FSM encoding; the loader mirrors these as 2-bit localparams.
  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_CKSUM = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

  // Opcodes fetched by the exec unit starting at ip0.
  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_LDI  = 8'h01,
    OP_ADD  = 8'h02,
    OP_SUB  = 8'h03,
    OP_JMP  = 8'h10,
    OP_JZ   = 8'h11,
    OP_ST   = 8'h20,
    OP_LD   = 8'h21,
    OP_HALT = 8'hFF
  } opcode_e;

endpackage

// File: rtl/mb8_io.sv
// Byte-memory port: we/ai/vi carry writes toward memory, vo returns
// read data. The loader only writes, so it leaves vo alone.
interface mb8_io #(
  parameter int ASZ = op_loader_pkg::ASZ_DEF,
  parameter int DSZ = op_loader_pkg::DSZ_DEF
) ();

  logic           we;
  logic [ASZ-1:0] ai;
  logic [DSZ-1:0] vi;
  logic [DSZ-1:0] vo;

  modport master (output we, output ai, output vi, input vo);
  modport slave  (input we, input ai, input vi, output vo);

endinterface

// File: rtl/op_loader.sv
// Opcode-image loader: streams len bytes from the rx handshake into
// byte memory starting at base, one byte per cycle, addresses wrapping
// modulo 2^ASZ. Each accepted byte is written on the following cycle.
//
// Build option: define LOADER_CKSUM_EN to accept one trailing checksum
// byte after the payload and flag err when it differs from the 8-bit
// sum of the payload bytes. Without it err is tied low and no trailer
// is consumed.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// LOAD  | accepting payload bytes, each written one cycle later
// CKSUM | accepting the trailer byte and comparing it (option only)
// DONE  | one-cycle done pulse, then back to IDLE
module op_loader
  import op_loader_pkg::*;
#(
  parameter int ASZ = ASZ_DEF,
  parameter int DSZ = DSZ_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mb8_io.master          mb_if,
  input  logic           start,
  input  logic [ASZ-1:0] base,
  input  logic [ASZ-1:0] len,
  input  logic           rx_vld,
  input  logic [DSZ-1:0] rx_dat,
  output logic           rx_rdy,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [ASZ-1:0] wr_cnt
);

  localparam logic [1:0] S_IDLE  = LD_IDLE;
  localparam logic [1:0] S_LOAD  = LD_LOAD;
  localparam logic [1:0] S_DONE  = LD_DONE;
`ifdef LOADER_CKSUM_EN
  localparam logic [1:0] S_CKSUM = LD_CKSUM;
  // The payload hands over to the trailer check.
  localparam logic [1:0] S_AFTER = S_CKSUM;
`else
  localparam logic [1:0] S_AFTER = S_DONE;
`endif

  logic [1:0]     st_q;
  logic [1:0]     st_d;
  logic [ASZ-1:0] base_q;
  logic [ASZ-1:0] rem_q;
  logic [ASZ-1:0] wr_cnt_q;
  logic           we_q;
  logic [ASZ-1:0] ai_q;
  logic [DSZ-1:0] vi_q;

  logic start_acc;
  logic rx_acc;
  logic ld_acc;
  logic last_byte;

  // vo is the read-return lane of the shared port; nothing here reads it.
  logic unused_vo;
  assign unused_vo = ^mb_if.vo;

  assign start_acc = start && (st_q == S_IDLE);
  assign rx_acc    = rx_vld && rx_rdy;
  assign ld_acc    = rx_acc && (st_q == S_LOAD);
  // rem_q counts payload bytes still to accept; terminal count is 1.
  assign last_byte = (rem_q == ASZ'(1));

  // Next-state selection.
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE: begin
        if (start) begin
          st_d = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_acc && last_byte) begin
          st_d = S_AFTER;
        end
      end
`ifdef LOADER_CKSUM_EN
      S_CKSUM: begin
        if (rx_acc) begin
          st_d = S_DONE;
        end
      end
`endif
      S_DONE: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Load context: latched base, remaining-byte down-counter and write count.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      rem_q    <= '0;
      wr_cnt_q <= '0;
    end else if (start_acc) begin
      base_q   <= base;
      rem_q    <= len;
      wr_cnt_q <= '0;
    end else if (ld_acc) begin
      rem_q    <= rem_q - ASZ'(1);
      wr_cnt_q <= wr_cnt_q + ASZ'(1);
    end
  end

  // Memory write stage: a payload byte accepted now is written next cycle.
  // Reset clears we_q so a byte still in flight is dropped, not written.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      ai_q <= '0;
      vi_q <= '0;
    end else begin
      we_q <= ld_acc;
      if (ld_acc) begin
        ai_q <= base_q + wr_cnt_q;
        vi_q <= rx_dat;
      end
    end
  end

`ifdef LOADER_CKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;

  // Running payload sum and trailer comparison; err holds until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (start_acc) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (ld_acc) begin
      sum_q <= sum_q + 8'(rx_dat);
    end else if (rx_acc && (st_q == S_CKSUM)) begin
      err_q <= (8'(rx_dat) != sum_q);
    end
  end

  assign err    = err_q;
  assign rx_rdy = (st_q == S_LOAD) || (st_q == S_CKSUM);
`else
  assign err    = 1'b0;
  assign rx_rdy = (st_q == S_LOAD);
`endif

  assign busy     = (st_q != S_IDLE);
  assign done     = (st_q == S_DONE);
  assign wr_cnt   = wr_cnt_q;
  assign mb_if.we = we_q;
  assign mb_if.ai = ai_q;
  assign mb_if.vi = vi_q;

endmodule

// File: tb/tb_op_loader.sv
// Bench for op_loader. Directed loads are driven cycle by cycle; each
// driver step records what the outputs must be (pending writes with the
// cycle they are due, done cycle, busy/rx_rdy windows) and a negedge
// compare process checks every output against that record each cycle.
// A sink captures the actual writes for literal spot checks.
module tb_op_loader;

  localparam int ASZ = 17;
  localparam int DSZ = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [ASZ-1:0] base;
  logic [ASZ-1:0] len;
  logic           rx_vld;
  logic [DSZ-1:0] rx_dat;
  logic           rx_rdy;
  logic           busy;
  logic           done;
  logic           err;
  logic [ASZ-1:0] wr_cnt;

  mb8_io #(.ASZ(ASZ), .DSZ(DSZ)) mb ();
  assign mb.vo = '0;

  op_loader #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk    (clk),
    .rst    (rst),
    .mb_if  (mb),
    .start  (start),
    .base   (base),
    .len    (len),
    .rx_vld (rx_vld),
    .rx_dat (rx_dat),
    .rx_rdy (rx_rdy),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Expected-behaviour record.
  typedef struct {
    int             due;
    logic [ASZ-1:0] a;
    logic [7:0]     d;
  } wr_t;

  wr_t wq[$];
  int  done_due = -1;
  int  busy_lo = 0, busy_hi = -1;
  int  rdy_lo = 0, rdy_hi = -1;
  int  clr_due = -1;
  int  err_due = -1;
  bit  err_val = 1'b0;
  int  m_wrcnt = 0;
  bit  m_err = 1'b0;
  bit  cmp_en = 1'b0;
  bit  exp_we;

  // Per-cycle comparison of every output against the record.
  always @(negedge clk) begin
    if (cmp_en) begin
      if (cyc == clr_due) begin
        m_wrcnt = 0;
        m_err   = 1'b0;
      end
      if (cyc == err_due) m_err = err_val;
      exp_we = (wq.size() > 0) && (wq[0].due == cyc);
      chk("we", 32'(mb.we), 32'(exp_we));
      if (exp_we) begin
        chk("ai", 32'(mb.ai), 32'(wq[0].a));
        chk("vi", 32'(mb.vi), 32'(wq[0].d));
        void'(wq.pop_front());
        m_wrcnt++;
      end
      chk("done", 32'(done), 32'(cyc == done_due));
      chk("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
      chk("rx_rdy", 32'(rx_rdy), 32'((cyc >= rdy_lo) && (cyc <= rdy_hi)));
      chk("wr_cnt", 32'(wr_cnt), 32'(m_wrcnt));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  // Sink: what actually reached memory.
  logic [7:0]     mem [int];
  logic [ASZ-1:0] wlog[$];
  int             done_cnt = 0;

  always @(negedge clk) begin
    if (mb.we === 1'b1) begin
      mem[int'(mb.ai)] = mb.vi;
      wlog.push_back(mb.ai);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pl[$];

  // Drive one load of pl from base b. gap inserts an idle rx cycle before
  // every byte after the first (and a stray start in the first gap);
  // rst_at>=0 asserts reset instead of presenting byte rst_at.
  task automatic do_load(input logic [ASZ-1:0] b, input bit gap, input int rst_at,
                         input bit trailer, input logic [7:0] tval);
    int s;
    int sum;
    s   = cyc;
    sum = 0;
    start = 1'b1;
    base  = b;
    len   = ASZ'(pl.size());
    clr_due = s + 1;
    busy_lo = s + 1;
    busy_hi = 1 << 30;
    wlog.delete();
    done_cnt = 0;
    if (pl.size() == 0) begin
      busy_hi  = s + 1;
      done_due = s + 1;
      rdy_lo   = 0;
      rdy_hi   = -1;
      tick();
      start = 1'b0;
      tick();
      tick();
      return;
    end
    rdy_lo = s + 1;
    rdy_hi = 1 << 30;
    tick();
    start = 1'b0;
    for (int i = 0; i < pl.size(); i++) begin
      if (gap && i > 0) begin
        rx_vld = 1'b0;
        rx_dat = 8'hEE;
        if (i == 1) begin
          start = 1'b1;
          base  = 17'h155;
          len   = 17'd9;
        end
        tick();
        start = 1'b0;
      end
      rx_vld = 1'b1;
      rx_dat = pl[i];
      if (i == rst_at) begin
        rst      = 1'b1;
        busy_hi  = cyc;
        rdy_hi   = cyc;
        clr_due  = cyc + 1;
        done_due = -1;
        tick();
        rst    = 1'b0;
        rx_vld = 1'b0;
        tick();
        tick();
        return;
      end
      wq.push_back('{due: cyc + 1, a: b + ASZ'(i), d: pl[i]});
      sum += int'(pl[i]);
      if (i == pl.size() - 1 && !trailer) begin
        done_due = cyc + 1;
        busy_hi  = cyc + 1;
        rdy_hi   = cyc;
      end
      tick();
    end
    if (trailer) begin
      rx_vld   = 1'b1;
      rx_dat   = tval;
      done_due = cyc + 1;
      busy_hi  = cyc + 1;
      rdy_hi   = cyc;
      err_due  = cyc + 1;
      err_val  = (tval != 8'(sum));
      tick();
    end
    rx_vld = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    base   = '0;
    len    = '0;
    rx_vld = 1'b0;
    rx_dat = '0;
    tick();
    tick();
    // Reset still high: a start here must be ignored.
    cmp_en = 1'b1;
    start  = 1'b1;
    len    = 17'd5;
    base   = 17'h40;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    tick();

    // Continuous stream at 'h100.
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    mem.delete();
    do_load(17'h100, 1'b0, -1, 1'b0, 8'h00);
    chk("t1_writes", 32'(wlog.size()), 32'd4);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_wr_cnt", 32'(wr_cnt), 32'd4);
    chk("t1_mem100", 32'(mem[32'h100]), 32'h01);
    chk("t1_mem103", 32'(mem[32'h103]), 32'h04);

    // Same load with rx_vld low every other cycle.
    mem.delete();
    do_load(17'h100, 1'b1, -1, 1'b0, 8'h00);
    chk("t2_writes", 32'(wlog.size()), 32'd4);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_mem101", 32'(mem[32'h101]), 32'h02);
    chk("t2_mem102", 32'(mem[32'h102]), 32'h03);
    chk("t2_no_stray", 32'(mem.exists(32'h155)), 32'd0);

    // Address wrap.
    pl = '{8'hAA, 8'hBB, 8'hCC};
    do_load(17'h1FFFE, 1'b0, -1, 1'b0, 8'h00);
    chk("t3_writes", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("t3_a0", 32'(wlog[0]), 32'h1FFFE);
      chk("t3_a1", 32'(wlog[1]), 32'h1FFFF);
      chk("t3_a2", 32'(wlog[2]), 32'h00000);
    end
    chk("t3_mem0", 32'(mem[0]), 32'hCC);

    // Zero-length load.
    pl.delete();
    do_load(17'h200, 1'b0, -1, 1'b0, 8'h00);
    chk("t4_writes", 32'(wlog.size()), 32'd0);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Reset after two of eight bytes.
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_load(17'h300, 1'b0, 2, 1'b0, 8'h00);
    chk("t5_writes", 32'(wlog.size()), 32'd2);
    chk("t5_done_cnt", 32'(done_cnt), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rx_rdy", 32'(rx_rdy), 32'd0);
    chk("t5_wr_cnt", 32'(wr_cnt), 32'd0);

    // Recovery after reset, gapped, different base.
    pl = '{8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h3C};
    do_load(17'h0FFFD, 1'b1, -1, 1'b0, 8'h00);
    chk("t6_writes", 32'(wlog.size()), 32'd5);
    chk("t6_mem", 32'(mem[32'h10001]), 32'h3C);

`ifdef LOADER_CKSUM_EN
    pl = '{8'h10, 8'h20, 8'h30};
    do_load(17'h400, 1'b0, -1, 1'b1, 8'h60);
    chk("t7_err_good", 32'(err), 32'd0);
    chk("t7_writes", 32'(wlog.size()), 32'd3);
    chk("t7_done_cnt", 32'(done_cnt), 32'd1);
    do_load(17'h400, 1'b0, -1, 1'b1, 8'h61);
    chk("t7_err_bad", 32'(err), 32'd1);
    chk("t7_writes_bad", 32'(wlog.size()), 32'd3);
    chk("t7_done_cnt_bad", 32'(done_cnt), 32'd1);
    chk("t7_no_trailer", 32'(mem.exists(32'h403)), 32'd0);
`endif

    chk("queue_drained", 32'(wq.size()), 32'd0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/op_loader.md
OP_LOADER -- requirements
Module: op_loader

Interface
REQ-001 Parameter ASZ, 17, memory address width in bits.
REQ-002 Parameter DSZ, 8, data byte width in bits.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mb_if  mb8_io.master  -  byte-memory write port: we (1), ai (ASZ), vi (DSZ); vo unused.
REQ-006 start  input  1  one-cycle pulse that begins a load.
REQ-007 base  input  ASZ  first write address, sampled on an accepted start.
REQ-008 len  input  ASZ  payload byte count, sampled on an accepted start.
REQ-009 rx_vld  input  1  source byte valid.
REQ-010 rx_dat  input  DSZ  source byte.
REQ-011 rx_rdy  output  1  loader ready to accept a byte.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  checksum mismatch flag.
REQ-015 wr_cnt  output  ASZ  bytes written since the last accepted start.

Function
REQ-016 The loader SHALL be the opcode-image writer paired with the exec unit's fetch port: it fills byte memory that exec later reads from ip0.
REQ-017 States SHALL be IDLE, LOAD, CKSUM and DONE.
REQ-018 In IDLE, a start with len>0 SHALL latch base and len, clear wr_cnt, clear err and go to LOAD.
REQ-019 In IDLE, a start with len==0 SHALL go directly to DONE with no memory writes.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 rx_rdy SHALL be 1 only in LOAD and CKSUM; a byte transfers when rx_vld&&rx_rdy.
REQ-022 A byte accepted in LOAD on cycle N SHALL produce we=1, ai=base+wr_cnt (mod 2^ASZ), vi=byte on cycle N+1; wr_cnt SHALL increment on cycle N+1.
REQ-023 Throughput SHALL be one byte per cycle; rx_vld gaps SHALL insert we=0 cycles without losing the address.
REQ-024 Addresses SHALL wrap modulo 2^ASZ: base='h1FFFF followed by 'h00000.
REQ-025 After the len-th byte is accepted, the state SHALL go to CKSUM if LOADER_CKSUM_EN is defined, else to DONE.
REQ-026 In DONE, done SHALL be 1 for exactly one cycle, and the state SHALL then return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 we SHALL be 0 in every cycle that has no pending accepted payload byte.
REQ-029 In CKSUM, the accepted byte SHALL NOT be written to memory.

Reset
REQ-030 While rst=1 on a clock edge, the state SHALL become IDLE, and we, rx_rdy, busy, done, err and wr_cnt SHALL become 0.
REQ-031 A reset during LOAD SHALL discard any pending write, so that no we pulse follows the reset edge; bytes already written stay in memory.
REQ-032 Reset SHALL take priority over start and rx_vld in the same cycle.

Configuration
REQ-033 Macro LOADER_CKSUM_EN defined: the loader SHALL keep an 8-bit running sum, mod 256, of the accepted payload bytes.
REQ-034 With LOADER_CKSUM_EN, one extra byte SHALL be accepted in CKSUM; err SHALL be set to 1 if that byte differs from the sum, and err SHALL hold until the next accepted start or reset.
REQ-035 Macro LOADER_CKSUM_EN undefined: the CKSUM state and the sum logic SHALL be absent, err SHALL be tied to 0, and no trailing byte SHALL be consumed.

Structure
REQ-036 The state enum ld_state_e and the ASZ/DSZ defaults SHALL live in the shared package alongside opcode_e.
REQ-037 The module SHALL be flat with no sub-module; the address/count datapath SHALL stay inline.

Verification
REQ-038 base='h100, len=4, bytes 01,02,03,04 with rx_vld continuous -> we on 4 consecutive cycles at ai 'h100-'h103, done pulses once, wr_cnt=4.
REQ-039 Same load with rx_vld low every other cycle -> identical memory contents, 4 we pulses, done after the 4th write.
REQ-040 base='h1FFFE, len=3 -> writes land at 'h1FFFE, 'h1FFFF, 'h00000.
REQ-041 len=0 -> done pulses one cycle after start, with no we and rx_rdy=0 throughout.
REQ-042 rst asserted after 2 of 8 bytes -> only 2 writes occur, and busy, rx_rdy and wr_cnt are 0 after the reset edge.
REQ-043 LOADER_CKSUM_EN, bytes 10,20,30, trailer 60 -> err=0; trailer 61 -> err=1, done pulses in both cases, and the trailer is never written.
